sm_board_ctrl: RTL and testbench
================================

// Module: sm_board_ctrl
// PURPOSE
//  Board-level run/step/display controller for the sm_top core.
//  - Drives sm_top clkEnable, clkDevide and regAddr from two push keys.
//  - Shows a 32-bit register value on a 4-bit LED bank, one nibble at a time.
//  - Sits between board keys/LEDs and sm_top.
// PARAMETERS
//  DEBOUNCE_W   16      debounce counter width; key must be stable 2^DEBOUNCE_W-1 clk
//  LONG_W       24      long-press counter width; long = held 2^LONG_W-1 clk
//  DISP_W       24      nibble-scan counter width; nibble advances every 2^DISP_W clk
//  DIV_DEFAULT  4'd2    clkDevide value after reset
//  REG_DEFAULT  5'd2    regAddr value after reset
// PORTS
//  clk        in   1   board clock (all logic in this domain)
//  rst_n      in   1   asynchronous active-low reset
//  key_a_n    in   1   raw key A, active-low, asynchronous to clk
//  key_b_n    in   1   raw key B, active-low, asynchronous to clk
//  regData    in   32  register value from sm_top
//  clkEnable  out  1   to sm_top; 1 = core clock runs
//  clkDevide  out  4   to sm_top clock divider select
//  regAddr    out  5   to sm_top register read address
//  led        out  4   displayed nibble
//  led_nib    out  3   index of displayed nibble (0 = bits 3:0)
// BEHAVIOUR
//  - Reset values (async): clkEnable=1, state=RUN, clkDevide=DIV_DEFAULT,
//    regAddr=REG_DEFAULT, led=0, led_nib=0, all counters 0.
//  - Key inputs: 2-FF synchroniser, then debouncer.
//    - Counter clears whenever the synced value differs from the stable value.
//    - Stable value takes the synced value when the counter reaches 2^DEBOUNCE_W-1.
//    - Press = stable 1->0, one-cycle pulse. Release = stable 0->1.
//  - FSM, clkEnable registered from next state:
//    - RUN  (en=1): A event -> PAUSE; B press -> regAddr+1, mod 32 (31 wraps to 0).
//    - PAUSE(en=0): A event -> RUN; B press -> STEP, load step count 2^(clkDevide+1).
//    - STEP (en=1): count down once per clk; at 1 -> PAUSE. A and B are ignored.
//    - Step length is one full divided core clock period, so exactly 1 core edge.
//    - Step counter is 17 bits.
//  - A and B events in the same cycle: A wins, B is dropped.
//  - Reset mid-STEP: returns to RUN, step counter cleared.
//  - Display:
//    - Free-running DISP_W counter; on wrap, led_nib <= led_nib+1 (7 wraps to 0).
//    - led <= regData[4*led_nib +: 4], registered, 1 clk latency.
//  - clkDevide changes only through the optional feature; regAddr changes only in RUN.
// CONFIGURATION
//  SM_BOARD_CTRL_SPEED_EN defined:
//    - Key A "event" is a short press, classified when the key is released.
//    - A held counter clears on press and saturates at 2^LONG_W-1.
//    - Release with counter < 2^LONG_W-1 gives a short event (FSM toggle above).
//    - Counter reaching 2^LONG_W-1 gives one long event: clkDevide+1 mod 16 (15 -> 0).
//      The following release produces nothing.
//    - Long event is accepted in any state, including STEP.
//    - A new clkDevide affects only steps started after it.
//  Not defined:
//    - Key A event = debounced press, acted on in the press cycle.
//    - clkDevide held constant at DIV_DEFAULT; no long-press logic synthesised.
// TESTING (DEBOUNCE_W=2, LONG_W=4, DISP_W=3, DIV_DEFAULT=1)
//  1. Reset -> clkEnable=1, regAddr=2, clkDevide=1, led=0.
//     regData=32'h87654321 -> led steps 1,2,..8 every 8 clk, led_nib 0..7, then wraps.
//  2. key_b pulse with 2-clk glitches (< debounce time) -> no change.
//     Clean B press in RUN -> regAddr 2->3. Repeat until 31 -> wraps to 0.
//  3. A press (release if SPEED_EN) -> clkEnable=0.
//     B press -> clkEnable=1 for exactly 4 clk, then 0. Second A event -> clkEnable=1.
//  4. During STEP, press A and B -> ignored; STEP ends after the count, state PAUSE.
//     In PAUSE, A and B debounced in the same cycle -> RUN, no step.
//  5. Assert rst_n=0 mid-STEP -> immediate clkEnable=1 with no clock edge.
//     Release -> RUN, regAddr=2.
//  6. SPEED_EN: hold A >= 15 clk -> clkDevide 1->2 once, FSM unchanged, release silent.
//     Next step lasts 8 clk. Hold with clkDevide=15 -> 0.
//     Without macro: long hold -> clkDevide stays 1, state toggles on press.

Source files
------------

// File: rtl/sm_board_ctrl_if.sv
// sm_board_ctrl_if
//   Core-facing bus between the board controller and sm_top.
//   regData   : 32-bit register value read back from the core
//   clkEnable : 1 = core clock runs
//   clkDevide : core clock divider select
//   regAddr   : core register read address
//   master = board controller side, slave = sm_top side.
interface sm_board_ctrl_if;
  logic [31:0] regData;
  logic        clkEnable;
  logic [3:0]  clkDevide;
  logic [4:0]  regAddr;

  modport master (input regData, output clkEnable, clkDevide, regAddr);
  modport slave  (output regData, input clkEnable, clkDevide, regAddr);
endinterface

// File: rtl/sm_board_ctrl.sv
// sm_board_ctrl
//   Board-level run/step/display controller for the sm_top core.
//   Two push keys drive run/pause/single-step and register selection; a 4-bit
//   LED bank scans the selected 32-bit register one nibble at a time.
// Ports
//   clk, rst_n       : board clock, asynchronous active-low reset
//   key_a_n, key_b_n : raw active-low keys, asynchronous to clk
//   bus (master)     : regData in; clkEnable, clkDevide, regAddr out
//   led              : displayed nibble
//   led_nib          : index of displayed nibble (0 = bits 3:0)
// Build option
//   SM_BOARD_CTRL_SPEED_EN : key A becomes short/long press aware; a long hold
//   bumps clkDevide. Undefined: key A acts on press, clkDevide is fixed.
module sm_board_ctrl #(
  parameter int         DEBOUNCE_W  = 16,
  parameter int         LONG_W      = 24,
  parameter int         DISP_W      = 24,
  parameter logic [3:0] DIV_DEFAULT = 4'd2,
  parameter logic [4:0] REG_DEFAULT = 5'd2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_a_n,
  input  logic                   key_b_n,
  sm_board_ctrl_if.master        bus,
  output logic [3:0]             led,
  output logic [2:0]             led_nib
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_PAUSE = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;

  // ---------------- key sync + debounce (bit 0 = A, bit 1 = B) ----------------
  logic [1:0]                 w_raw;
  logic [1:0]                 r_sync1, r_sync2, r_stable;
  logic [1:0][DEBOUNCE_W-1:0] r_db_cnt;
  logic [1:0]                 w_flip;   // stable value updates this cycle
  logic [1:0]                 w_press;  // stable 1->0

  assign w_raw = {key_b_n, key_a_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    assign w_flip[k]  = (r_sync2[k] != r_stable[k]) && (r_db_cnt[k] == {DEBOUNCE_W{1'b1}});
    assign w_press[k] = w_flip[k] & ~r_sync2[k];
  end

  // Counter runs only while the synced key disagrees with the stable value;
  // any return to agreement (a glitch) restarts the qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_db_cnt[k] <= '0;
        end else if (w_flip[k]) begin
          r_stable[k] <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // ---------------- key A event / divider ----------------
  logic       w_ev_a;
  logic       w_ev_b;
  logic [3:0] w_div;

  assign w_ev_b = w_press[1];

`ifdef SM_BOARD_CTRL_SPEED_EN
  localparam logic [LONG_W-1:0] LONG_MAX = '1;
  logic [LONG_W-1:0] r_held;
  logic [3:0]        r_div;
  logic              w_a_rel;
  logic              w_long;

  assign w_a_rel = w_flip[0] & r_sync2[0];
  // Long fires on the cycle the hold counter saturates; a release landing on
  // that same cycle is still a short press.
  assign w_long  = ~r_stable[0] & ~w_a_rel & (r_held == LONG_MAX - 1'b1);
  assign w_ev_a  = w_a_rel & (r_held != LONG_MAX);
  assign w_div   = r_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held <= '0;
      r_div  <= DIV_DEFAULT;
    end else begin
      if (w_press[0])                          r_held <= '0;
      else if (~r_stable[0] && r_held != LONG_MAX) r_held <= r_held + 1'b1;
      if (w_long) r_div <= r_div + 4'd1;
    end
  end
`else
  assign w_ev_a = w_press[0];
  assign w_div  = DIV_DEFAULT;
`endif

  // ---------------- run / pause / step FSM ----------------
  logic [1:0]  r_state, w_state_nx;
  logic [16:0] r_step, w_step_nx;
  logic [4:0]  r_addr, w_addr_nx;
  logic        r_clk_en;
  logic [4:0]  w_shamt;

  // One full divided core period: 2^(clkDevide+1) board clocks.
  assign w_shamt = {1'b0, w_div} + 5'd1;

  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_addr_nx  = r_addr;
    case (r_state)
      S_RUN: begin
        if (w_ev_a)      w_state_nx = S_PAUSE;
        else if (w_ev_b) w_addr_nx  = r_addr + 5'd1;
      end
      S_PAUSE: begin
        if (w_ev_a) begin
          w_state_nx = S_RUN;
        end else if (w_ev_b) begin
          w_state_nx = S_STEP;
          w_step_nx  = 17'd1 << w_shamt;
        end
      end
      S_STEP: begin
        if (r_step <= 17'd1) begin
          w_state_nx = S_PAUSE;
          w_step_nx  = '0;
        end else begin
          w_step_nx  = r_step - 17'd1;
        end
      end
      default: w_state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_step   <= '0;
      r_addr   <= REG_DEFAULT;
      r_clk_en <= 1'b1;
    end else begin
      r_state  <= w_state_nx;
      r_step   <= w_step_nx;
      r_addr   <= w_addr_nx;
      r_clk_en <= (w_state_nx != S_PAUSE);
    end
  end

  assign bus.clkEnable = r_clk_en;
  assign bus.clkDevide = w_div;
  assign bus.regAddr   = r_addr;

  // ---------------- nibble display ----------------
  logic [DISP_W-1:0] r_disp_cnt;
  logic [2:0]        r_led_nib;
  logic [3:0]        r_led;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_cnt <= '0;
      r_led_nib  <= '0;
      r_led      <= '0;
    end else begin
      r_disp_cnt <= r_disp_cnt + 1'b1;
      if (r_disp_cnt == {DISP_W{1'b1}}) r_led_nib <= r_led_nib + 3'd1;
      r_led <= bus.regData[{r_led_nib, 2'b00} +: 4];
    end
  end

  assign led     = r_led;
  assign led_nib = r_led_nib;

endmodule

// File: tb/tb_sm_board_ctrl.sv
// tb_sm_board_ctrl
//   Randomized key/display stimulus checked against a behavioural model of the
//   board controller (run/pause flag, register address, divider, step length,
//   nibble scan derived from the clock count since reset).
module tb_sm_board_ctrl;
  localparam int         DBW  = 2;
  localparam int         LW   = 4;
  localparam int         DW   = 3;
  localparam logic [3:0] DIVD = 4'd1;
  localparam logic [4:0] REGD = 5'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_a_n = 1'b1;
  logic       key_b_n = 1'b1;
  logic [3:0] led;
  logic [2:0] led_nib;

  sm_board_ctrl_if bus();

  sm_board_ctrl #(
    .DEBOUNCE_W (DBW),
    .LONG_W     (LW),
    .DISP_W     (DW),
    .DIV_DEFAULT(DIVD),
    .REG_DEFAULT(REGD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_a_n(key_a_n),
    .key_b_n(key_b_n),
    .bus    (bus),
    .led    (led),
    .led_nib(led_nib)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model
  int m_addr, m_div;
  bit m_run;

  // clocks since reset release; lengths of finished clkEnable-high runs
  int edges;
  int runlen;
  int runs[$];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;

  always @(negedge clk)
    if (!rst_n) runlen <= 0;
    else if (bus.clkEnable) runlen <= runlen + 1;
    else if (runlen != 0) begin
      runs.push_back(runlen);
      runlen <= 0;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".en"},   32'(bus.clkEnable), 32'(m_run));
    chk({tag, ".addr"}, 32'(bus.regAddr),   32'(m_addr));
    chk({tag, ".div"},  32'(bus.clkDevide), 32'(m_div));
  endtask

  task automatic model_reset();
    m_addr = REGD;
    m_div  = DIVD;
    m_run  = 1'b1;
  endtask

  task automatic hold_key(input bit a, input bit b, input int len);
    if (a) key_a_n = 1'b0;
    if (b) key_b_n = 1'b0;
    tick(len);
    key_a_n = 1'b1;
    key_b_n = 1'b1;
    tick($urandom_range(14, 18));
  endtask

  task automatic op_a(input bit long_hold);
    hold_key(1'b1, 1'b0, long_hold ? 26 : $urandom_range(8, 11));
`ifdef SM_BOARD_CTRL_SPEED_EN
    if (long_hold) m_div = (m_div + 1) % 16;
    else           m_run = !m_run;
`else
    m_run = !m_run;
`endif
    check_model(long_hold ? "opA_long" : "opA");
  endtask

  task automatic op_b();
    int n0;
    n0 = runs.size();
    hold_key(1'b0, 1'b1, $urandom_range(8, 11));
    if (m_run) m_addr = (m_addr + 1) % 32;
    else chk("step_len", (runs.size() == n0 + 1) ? runs[n0] : -1, 1 << (m_div + 1));
    check_model("opB");
  endtask

  task automatic glitch_b();
    int n0;
    n0 = runs.size();
    key_b_n = 1'b0;
    tick($urandom_range(1, 2));
    key_b_n = 1'b1;
    tick(12);
    chk("glitch_runs", runs.size(), n0);
    check_model("glitch");
  endtask

  task automatic disp_check(input int n, input string tag);
    logic [31:0] rd;
    int k, nib;
    for (int i = 0; i < n; i++) begin
      tick(1);
      rd  = bus.regData;
      k   = edges;
      nib = (k == 0) ? 0 : ((k - 1) / 8) % 8;
      chk({tag, ".led"},     32'(led),     (k == 0) ? 0 : (rd >> (4 * nib)) & 32'hF);
      chk({tag, ".led_nib"}, 32'(led_nib), (k / 8) % 8);
    end
  endtask

  initial begin
    int n0;
    bit found;
    int r;

    // ---- 1: reset values and nibble scan ----
    rst_n = 1'b0;
    bus.regData = 32'h87654321;
    model_reset();
    tick(3);
    check_model("reset");
    chk("reset.led", 32'(led), 0);
    chk("reset.led_nib", 32'(led_nib), 0);
    rst_n = 1'b1;
    disp_check(72, "disp_fixed");
    bus.regData = $urandom;
    disp_check(24, "disp_rand");

    // ---- 2: glitches, B presses in RUN with wrap ----
    for (int i = 0; i < 3; i++) glitch_b();
    for (int i = 0; i < 32; i++) op_b();

    // ---- 3: pause, single step, glitch in pause, resume ----
    op_a(1'b0);
    op_b();
    glitch_b();
    op_a(1'b0);

    // ---- 4: A during STEP is ignored ----
    op_a(1'b0);
    n0 = runs.size();
    key_b_n = 1'b0;
    tick(1);
    key_a_n = 1'b0;
    tick(9);
    key_a_n = 1'b1;
    key_b_n = 1'b1;
    tick(18);
    chk("stepA_len", (runs.size() > n0) ? runs[n0] : -1, 1 << (m_div + 1));
`ifdef SM_BOARD_CTRL_SPEED_EN
    m_run = 1'b1;  // the A release lands after the step, in PAUSE
`endif
    check_model("stepA");
    if (m_run) op_a(1'b0);

    // A and B debounced in the same cycle while paused: A wins, no step
    n0 = runs.size();
`ifdef SM_BOARD_CTRL_SPEED_EN
    key_a_n = 1'b0;
    tick(9);
    key_a_n = 1'b1;
    key_b_n = 1'b0;
    tick(10);
    key_b_n = 1'b1;
    tick(16);
`else
    hold_key(1'b1, 1'b1, 10);
`endif
    m_run = 1'b1;
    chk("sameAB_runs", runs.size(), n0);
    check_model("sameAB");

    // ---- 5: reset while paused and mid-STEP ----
    op_a(1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_pause.en", 32'(bus.clkEnable), 1);
    tick(2);
    rst_n = 1'b1;
    model_reset();
    tick(2);
    op_b();
    op_a(1'b0);
    key_b_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (bus.clkEnable) found = 1'b1;
    end
    chk("step_start", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rst_step");
    chk("rst_step.led", 32'(led), 0);
    key_b_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check_model("after_rst");
    op_b();

    // ---- randomized mix ----
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)       op_a(1'b0);
      else if (r < 8)  op_b();
      else if (r == 8) glitch_b();
`ifdef SM_BOARD_CTRL_SPEED_EN
      else if (m_div < 2) op_a(1'b1);
      else op_a(1'b0);
`else
      else op_a(1'b1);  // long hold is just a press here
`endif
    end

`ifdef SM_BOARD_CTRL_SPEED_EN
    // ---- 6: long press bumps divider; step follows new divider; wrap ----
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_reset();
    tick(2);
    op_a(1'b1);
    op_a(1'b0);
    op_b();
    for (int i = 0; i < 14; i++) op_a(1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard time limit
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
